// File: rtl/mux4_rr_arbiter.sv
// mux4_rr_arbiter
//
// Shares one N-bit 4:1 select path between four requesters using a
// round-robin policy. The owner of the mux is tracked in registered
// grant/s outputs. The selected word is presented to a single downstream
// consumer under a valid/ready handshake. Each grant ends after MAX_HOLD
// accepted transfers, so one requester cannot keep the path forever.
//
// Parameters
//   N        : width of each requester word and of f
//   MAX_HOLD : accepted transfers allowed per grant before rotation (>= 1)
//
// Ports
//   clk            : system clock, all state changes on the rising edge
//   reset          : synchronous, active-high reset
//   req[3:0]       : request per requester, bit i means wi holds a word
//   w0..w3[N-1:0]  : requester data words
//   ready          : downstream accepts f this cycle
//   grant[3:0]     : one-hot current owner, zero when idle (registered)
//   s[1:0]         : index of the current owner (registered)
//   f[N-1:0]       : selected word while valid, otherwise zero
//   valid          : f carries a word from the granted requester

module mux4_rr_arbiter #(
    parameter int N        = 3,
    parameter int MAX_HOLD = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [3:0]   req,
    input  logic [N-1:0] w0,
    input  logic [N-1:0] w1,
    input  logic [N-1:0] w2,
    input  logic [N-1:0] w3,
    input  logic         ready,
    output logic [3:0]   grant,
    output logic [1:0]   s,
    output logic [N-1:0] f,
    output logic         valid
);

    localparam int HC_W = $clog2(MAX_HOLD) + 1;
    localparam logic [HC_W-1:0] HOLD_LAST = HC_W'(MAX_HOLD - 1);

    typedef enum logic {
        IDLE,
        GRANT
    } state_t;

    state_t          state_q, state_d;
    logic [3:0]      grant_q, grant_d;
    logic [1:0]      s_q, s_d;
    logic [1:0]      ptr_q, ptr_d;
    logic [HC_W-1:0] hold_cnt_q, hold_cnt_d;

    logic            pick_found;
    logic [1:0]      pick_idx;
    logic [1:0]      cand;
    logic            rotate;
    logic [N-1:0]    w_sel;

    // Round-robin search. The search starts at ptr and wraps modulo 4, and
    // the first requester found wins. After a grant, ptr already points one
    // past the owner. A release can therefore reuse this search in the same
    // cycle. The owner can only win again when nobody else is asking.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = 2'd0;
        cand       = 2'd0;
        for (int i = 0; i < 4; i++) begin
            cand = ptr_q + 2'(i);
            if (!pick_found && req[cand]) begin
                pick_found = 1'b1;
                pick_idx   = cand;
            end
        end
    end

    // The output word comes from the registered select, so f only follows
    // the data inputs and never the arbitration logic.
    always_comb begin
        case (s_q)
            2'd0:    w_sel = w0;
            2'd1:    w_sel = w1;
            2'd2:    w_sel = w2;
            default: w_sel = w3;
        endcase
    end

    assign valid = (state_q == GRANT) && req[s_q];
    assign f     = valid ? w_sel : '0;
    assign grant = grant_q;
    assign s     = s_q;

    // Next-state logic. In GRANT, the grant is released when the owner drops
    // its request. It is also released on the transfer that uses up the hold
    // budget. A stalled transfer (ready low) leaves the count unchanged. On
    // release, the next owner is picked in the same cycle, so a handoff
    // leaves no empty cycle.
    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        s_d        = s_q;
        ptr_d      = ptr_q;
        hold_cnt_d = hold_cnt_q;
        rotate     = 1'b0;

        case (state_q)
            IDLE: begin
                if (pick_found) begin
                    state_d    = GRANT;
                    grant_d    = 4'b0001 << pick_idx;
                    s_d        = pick_idx;
                    ptr_d      = pick_idx + 2'd1;
                    hold_cnt_d = '0;
                end
            end
            GRANT: begin
                if (!req[s_q]) begin
                    rotate = 1'b1;
                end else if (ready) begin
                    if (hold_cnt_q == HOLD_LAST) begin
                        rotate = 1'b1;
                    end else begin
                        hold_cnt_d = hold_cnt_q + 1'b1;
                    end
                end

                if (rotate) begin
                    hold_cnt_d = '0;
                    if (pick_found) begin
                        grant_d = 4'b0001 << pick_idx;
                        s_d     = pick_idx;
                        ptr_d   = pick_idx + 2'd1;
                    end else begin
                        state_d = IDLE;
                        grant_d = 4'b0000;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                grant_d = 4'b0000;
            end
        endcase
    end

    // All state sits in one register stage. Reset returns everything to the
    // idle, pointer-at-zero condition. Any word in flight is dropped, because
    // valid goes low with the state.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            grant_q    <= 4'b0000;
            s_q        <= 2'd0;
            ptr_q      <= 2'd0;
            hold_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            s_q        <= s_d;
            ptr_q      <= ptr_d;
            hold_cnt_q <= hold_cnt_d;
        end
    end

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// tb_mux4_rr_arbiter
//
// Directed testbench for mux4_rr_arbiter. Two instances share the same
// stimulus. "dut" uses MAX_HOLD=4 and "dut2" uses MAX_HOLD=2, so the
// contention rotation sequence can be checked on short grants. Inputs change
// 1 time unit after a rising edge. Outputs are sampled before the next edge.

module tb_mux4_rr_arbiter;

    logic       clk;
    logic       reset;
    logic [3:0] req;
    logic [2:0] w0, w1, w2, w3;
    logic       ready;

    logic [3:0] grant, grant2;
    logic [1:0] s, s2;
    logic [2:0] f, f2;
    logic       valid, valid2;

    int testsRun;
    int testsFailed;

    mux4_rr_arbiter #(.N(3), .MAX_HOLD(4)) dut (
        .clk   (clk),
        .reset (reset),
        .req   (req),
        .w0    (w0),
        .w1    (w1),
        .w2    (w2),
        .w3    (w3),
        .ready (ready),
        .grant (grant),
        .s     (s),
        .f     (f),
        .valid (valid)
    );

    mux4_rr_arbiter #(.N(3), .MAX_HOLD(2)) dut2 (
        .clk   (clk),
        .reset (reset),
        .req   (req),
        .w0    (w0),
        .w1    (w1),
        .w2    (w2),
        .w3    (w3),
        .ready (ready),
        .grant (grant2),
        .s     (s2),
        .f     (f2),
        .valid (valid2)
    );

    // Free-running clock with a 10-unit period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Compares one observed value with its expected value, counts the check
    // and reports a mismatch.
    task automatic checkOutput(input string tag, input logic [31:0] obs,
                               input logic [31:0] exp);
        testsRun++;
        if (obs !== exp) begin
            testsFailed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Drives the request and ready inputs, then lets the combinational
    // outputs settle.
    task automatic applyStimulus(input logic [3:0] r, input logic rd);
        req   = r;
        ready = rd;
        #1;
    endtask

    // Moves past the next rising edge so the registered outputs can be sampled.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expected dut2 owner after each edge under full contention with
    // MAX_HOLD=2. Each owner keeps the grant for two transfers.
    logic [3:0] rotGrant [10] = '{4'b0001, 4'b0001, 4'b0010, 4'b0010,
                                  4'b0100, 4'b0100, 4'b1000, 4'b1000,
                                  4'b0001, 4'b0001};
    logic [2:0] rotWord  [10] = '{3'd1, 3'd1, 3'd2, 3'd2, 3'd5, 3'd5,
                                  3'd6, 3'd6, 3'd1, 3'd1};

    initial begin
        testsRun    = 0;
        testsFailed = 0;
        reset = 1'b1;
        req   = 4'b0000;
        ready = 1'b0;
        w0 = 3'd1;
        w1 = 3'd2;
        w2 = 3'd5;
        w3 = 3'd6;

        // Reset state.
        tick();
        tick();
        checkOutput("rst_grant", 32'(grant), 32'h0);
        checkOutput("rst_s", 32'(s), 32'h0);
        checkOutput("rst_valid", 32'(valid), 32'h0);
        checkOutput("rst_f", 32'(f), 32'h0);

        // Single requester: grant 2 once, then keep valid with no gap
        // through two hold-limit regrants.
        reset = 1'b0;
        applyStimulus(4'b0100, 1'b1);
        checkOutput("single_idle_valid", 32'(valid), 32'h0);
        tick();
        checkOutput("single_grant", 32'(grant), 32'h4);
        checkOutput("single_s", 32'(s), 32'h2);
        for (int i = 0; i < 9; i++) begin
            checkOutput("single_valid", 32'(valid), 32'h1);
            checkOutput("single_f", 32'(f), 32'h5);
            tick();
            checkOutput("single_regrant", 32'(grant), 32'h4);
        end

        // Full contention on dut2 (MAX_HOLD=2): owners 0,1,2,3,0 in turn,
        // two transfers each.
        reset = 1'b1;
        applyStimulus(4'b0000, 1'b0);
        tick();
        reset = 1'b0;
        applyStimulus(4'b1111, 1'b1);
        for (int i = 0; i < 10; i++) begin
            tick();
            checkOutput("rot_grant", 32'(grant2), 32'(rotGrant[i]));
            checkOutput("rot_valid", 32'(valid2), 32'h1);
            checkOutput("rot_f", 32'(f2), 32'(rotWord[i]));
        end

        // Backpressure on dut (MAX_HOLD=4): owner 1 stalls 5 cycles, then
        // needs 4 accepted transfers before requester 3 takes over.
        reset = 1'b1;
        applyStimulus(4'b0000, 1'b0);
        tick();
        reset = 1'b0;
        applyStimulus(4'b1010, 1'b0);
        tick();
        checkOutput("bp_grant", 32'(grant), 32'h2);
        for (int i = 0; i < 5; i++) begin
            checkOutput("bp_stall_valid", 32'(valid), 32'h1);
            checkOutput("bp_stall_f", 32'(f), 32'h2);
            tick();
            checkOutput("bp_stall_grant", 32'(grant), 32'h2);
        end
        applyStimulus(4'b1010, 1'b1);
        for (int i = 0; i < 3; i++) begin
            tick();
            checkOutput("bp_xfer_grant", 32'(grant), 32'h2);
        end
        tick();
        checkOutput("bp_rotate_grant", 32'(grant), 32'h8);
        checkOutput("bp_rotate_s", 32'(s), 32'h3);
        checkOutput("bp_rotate_f", 32'(f), 32'h6);

        // Owner drop: owner 0 makes one transfer and then drops its request.
        // Valid falls in that same cycle, and requester 3 is granted at the
        // next edge.
        reset = 1'b1;
        applyStimulus(4'b0000, 1'b0);
        tick();
        reset = 1'b0;
        applyStimulus(4'b1001, 1'b1);
        tick();
        checkOutput("drop_grant0", 32'(grant), 32'h1);
        tick();
        applyStimulus(4'b1000, 1'b1);
        checkOutput("drop_valid", 32'(valid), 32'h0);
        checkOutput("drop_f", 32'(f), 32'h0);
        tick();
        checkOutput("drop_grant3", 32'(grant), 32'h8);
        checkOutput("drop_s", 32'(s), 32'h3);
        checkOutput("drop_f3", 32'(f), 32'h6);

        // Idle return: requester 3 drops its request and the arbiter goes
        // idle. The pointer has wrapped to 0, so a request from 0 is granted
        // next.
        applyStimulus(4'b0000, 1'b1);
        tick();
        checkOutput("idle_grant", 32'(grant), 32'h0);
        checkOutput("idle_valid", 32'(valid), 32'h0);
        checkOutput("idle_f", 32'(f), 32'h0);
        applyStimulus(4'b0001, 1'b1);
        tick();
        checkOutput("wrap_grant", 32'(grant), 32'h1);
        checkOutput("wrap_s", 32'(s), 32'h0);
        checkOutput("wrap_f", 32'(f), 32'h1);

        // Reset mid-grant: requester 2 owns the mux when reset is asserted.
        // After reset, requester 0 is granted first.
        applyStimulus(4'b0100, 1'b1);
        tick();
        checkOutput("mid_grant2", 32'(grant), 32'h4);
        reset = 1'b1;
        applyStimulus(4'b1111, 1'b1);
        tick();
        checkOutput("mid_rst_grant", 32'(grant), 32'h0);
        checkOutput("mid_rst_s", 32'(s), 32'h0);
        checkOutput("mid_rst_valid", 32'(valid), 32'h0);
        checkOutput("mid_rst_f", 32'(f), 32'h0);
        reset = 1'b0;
        tick();
        checkOutput("post_rst_grant", 32'(grant), 32'h1);
        checkOutput("post_rst_f", 32'(f), 32'h1);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
